led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  MMIO slot that drives a W-bit LED bank from a programmable table of (mask, duration) steps.
//  Software loads up to N_STEPS entries and starts the sequencer; hardware plays them back with
//  millisecond timing, one-shot or looping. It replaces per-LED blink timing with a centrally
//  scheduled pattern. Sits on the same slot bus as the other LED/GPO cores; dout drives the board LEDs.
// PARAMETERS
//  W            16       LED output width; masks are wr_data[W-1:0], W <= 16
//  N_STEPS      8        step table depth, power of 2, <= 16
//  TICKS_PER_MS 100_000  clk cycles per 1 ms tick (100 MHz clock); bench overrides to 10
// PORTS
//  clk      in   1   system clock, all logic on rising edge
//  reset    in   1   synchronous, active-high reset
//  cs       in   1   slot select
//  read     in   1   read strobe (no side effects)
//  write    in   1   write strobe; register written when cs && write
//  addr     in   5   register address
//  wr_data  in   32  write data
//  rd_data  out  32  read data, combinational from addr
//  dout     out  W   LED drive
// BEHAVIOUR
//  Register map:
//   0 CTRL   wr: bit0 START (pulse), bit1 STOP (pulse), bit2 LOOP (stored), bit3 CLR_DONE (pulse)
//            rd: {29'b0, LOOP, 2'b0}
//   1 NSTEP  rd/wr [3:0]; effective count = 1 if 0, N_STEPS if > N_STEPS
//   2 STATUS rd: [0] busy, [1] done (sticky), [11:8] current step index; writes ignored
//   16+k     step k (k < N_STEPS) rd/wr: [15:0] mask, [31:16] duration ms (0 treated as 1)
//   other    rd 0, writes ignored; step addresses >= 16+N_STEPS read 0, writes ignored
//  Reset: state IDLE, dout=0, step=0, busy=0, done=0, LOOP=0, NSTEP=0, table=0, counters=0.
//  FSM:
//   IDLE: dout=0, busy=0. START write -> RUN at step 0; done cleared.
//   RUN : busy=1. On step entry: dout <= mask[step] (registered), prescaler=0, ms_cnt=0.
//         prescaler counts 0..TICKS_PER_MS-1; wrap = ms tick; ms_cnt++ on tick.
//         Step ends on the tick where ms_cnt reaches duration: step held exactly
//         duration*TICKS_PER_MS cycles, next step's mask visible the following cycle.
//         Last step end: LOOP=1 -> step 0 (no gap cycle); LOOP=0 -> IDLE, dout=0, done=1.
//  Latency: START written in cycle t -> busy=1 and dout=mask[0] in cycle t+1.
//  STOP: any state -> IDLE next cycle, dout=0, done unchanged, step reset to 0.
//  START while RUN: restart at step 0 with fresh counters. START and STOP in same write: STOP wins.
//  CLR_DONE clears done; same-cycle done set by sequence end wins over CLR_DONE.
//  Table/NSTEP/LOOP writes during RUN are legal: mask/duration sampled at each step entry
//   (current step unaffected); NSTEP/LOOP evaluated at each step end.
//  Duration arithmetic: 16-bit ms_cnt, no overflow (max 65535 ms per step).
//  Reset mid-RUN: all state returns to reset values next cycle, no further dout change.
// TESTING (TICKS_PER_MS=10)
//  1 Reset: after reset, dout=0, STATUS=0, reads of 16..23 return 0.
//  2 One-shot: step0={mask 0x00FF,dur 2}, step1={0xFF00,3}, NSTEP=2, START -> dout 0x00FF for 20
//    cycles, 0xFF00 for 30 cycles, then dout=0, STATUS=0x2 (done, not busy).
//  3 Loop: same table, CTRL=0x5 -> pattern repeats with 50-cycle period; CTRL=0x2 mid step 1
//    -> dout=0, busy=0 next cycle, done=0.
//  4 Boundaries: dur=0 step lasts 10 cycles; NSTEP=0 plays only step 0; NSTEP=15 plays 8 steps.
//  5 Collisions: CTRL=0x3 while IDLE -> stays IDLE; START during step 1 -> step 0 mask next cycle;
//    CLR_DONE on done-setting cycle -> done=1.
//  6 Live edit + reset: rewrite step1 mask to 0xAAAA during step 0 -> 0xAAAA shown at step 1;
//    assert reset mid-step -> dout=0, STATUS=0 next cycle.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer slot: plays a table of (mask, duration) steps onto
// a W-bit LED bank with millisecond timing, one-shot or looping.
module led_pattern_sequencer #(
  parameter int W            = 16,
  parameter int N_STEPS      = 8,
  parameter int TICKS_PER_MS = 100_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [W-1:0]  dout
);

  localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // A programmed duration of zero still holds the step for one millisecond.
  function automatic logic [15:0] dur_eff(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  // configuration and step table
  logic                loop_r;
  logic [3:0]          nstep_r;
  logic [15:0]         mask_r [N_STEPS];
  logic [15:0]         dur_r  [N_STEPS];

  // playback state
  state_t              state_r;
  logic [SW-1:0]       step_r;
  logic [PW-1:0]       presc_r;
  logic [15:0]         ms_cnt_r;
  logic [15:0]         cur_dur_r;
  logic                busy_r;
  logic                done_r;

  // decode and sequencing helpers
  logic                wr_s;
  logic                ctrl_wr_s;
  logic                start_s;
  logic                stop_s;
  logic                clr_s;
  logic                tbl_sel_s;
  logic [SW-1:0]       tbl_idx_s;
  logic [4:0]          n_eff_s;
  logic                tick_s;
  logic                step_end_s;
  logic                last_s;
  logic [SW-1:0]       next_idx_s;
  logic                done_set_s;
  logic [3:0]          step4_s;

  assign wr_s      = cs && write;
  assign ctrl_wr_s = wr_s && (addr == 5'd0);
  assign start_s   = ctrl_wr_s && wr_data[0];
  assign stop_s    = ctrl_wr_s && wr_data[1];
  assign clr_s     = ctrl_wr_s && wr_data[3];
  assign tbl_sel_s = addr[4] && ({1'b0, addr[3:0]} < 5'(N_STEPS));
  assign tbl_idx_s = addr[SW-1:0];
  assign step4_s   = 4'(step_r);

  // Clamp the programmed step count into 1..N_STEPS.
  always_comb begin
    if (nstep_r == 4'd0) begin
      n_eff_s = 5'd1;
    end else if ({1'b0, nstep_r} > 5'(N_STEPS)) begin
      n_eff_s = 5'(N_STEPS);
    end else begin
      n_eff_s = {1'b0, nstep_r};
    end
  end

  // Millisecond tick, step-end and wrap decisions for the running sequence.
  always_comb begin
    tick_s     = (state_r == RUN) && (presc_r == PW'(TICKS_PER_MS - 1));
    step_end_s = tick_s && (({1'b0, ms_cnt_r} + 17'd1) == {1'b0, cur_dur_r});
    last_s     = ((5'(step_r) + 5'd1) >= n_eff_s);
    if (last_s) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = step_r + SW'(1);
    end
    done_set_s = step_end_s && last_s && !loop_r && !stop_s && !start_s;
  end

  // Software-visible configuration: LOOP bit, step count and step table.
  always_ff @(posedge clk) begin
    if (reset) begin
      loop_r  <= 1'b0;
      nstep_r <= 4'd0;
      for (int k = 0; k < N_STEPS; k++) begin
        mask_r[k] <= 16'd0;
        dur_r[k]  <= 16'd0;
      end
    end else begin
      if (ctrl_wr_s) begin
        loop_r <= wr_data[2];
      end
      if (wr_s && (addr == 5'd1)) begin
        nstep_r <= wr_data[3:0];
      end
      if (wr_s && tbl_sel_s) begin
        mask_r[tbl_idx_s] <= wr_data[15:0];
        dur_r[tbl_idx_s]  <= wr_data[31:16];
      end
    end
  end

  // Playback FSM: step timing, registered LED drive and busy/done status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      step_r    <= '0;
      presc_r   <= '0;
      ms_cnt_r  <= 16'd0;
      cur_dur_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dout      <= '0;
    end else begin
      if (stop_s) begin
        state_r  <= IDLE;
        step_r   <= '0;
        presc_r  <= '0;
        ms_cnt_r <= 16'd0;
        busy_r   <= 1'b0;
        dout     <= '0;
      end else if (start_s) begin
        state_r   <= RUN;
        step_r    <= '0;
        presc_r   <= '0;
        ms_cnt_r  <= 16'd0;
        cur_dur_r <= dur_eff(dur_r[0]);
        busy_r    <= 1'b1;
        dout      <= mask_r[0][W-1:0];
      end else begin
        case (state_r)
          RUN: begin
            if (tick_s) begin
              presc_r <= '0;
              if (step_end_s) begin
                ms_cnt_r <= 16'd0;
                if (last_s && !loop_r) begin
                  state_r <= IDLE;
                  step_r  <= '0;
                  busy_r  <= 1'b0;
                  dout    <= '0;
                end else begin
                  step_r    <= next_idx_s;
                  cur_dur_r <= dur_eff(dur_r[next_idx_s]);
                  dout      <= mask_r[next_idx_s][W-1:0];
                end
              end else begin
                ms_cnt_r <= ms_cnt_r + 16'd1;
              end
            end else begin
              presc_r <= presc_r + PW'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            dout    <= '0;
          end
        endcase
      end
      // sequence end beats CLR_DONE; a winning START clears done
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (start_s && !stop_s) begin
        done_r <= 1'b0;
      end else if (clr_s) begin
        done_r <= 1'b0;
      end else begin
        done_r <= done_r;
      end
    end
  end

  // Combinational register read mux; reads have no side effects.
  always_comb begin
    rd_data = 32'd0;
    case (addr)
      5'd0: rd_data = {29'd0, loop_r, 2'd0};
      5'd1: rd_data = {28'd0, nstep_r};
      5'd2: rd_data = {20'd0, step4_s, 6'd0, done_r, busy_r};
      default: begin
        if (tbl_sel_s) begin
          rd_data = {dur_r[tbl_idx_s], mask_r[tbl_idx_s]};
        end else begin
          rd_data = 32'd0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer with 10 clocks per ms.
module tb_led_pattern_sequencer;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [15:0] dout;

  int errors;
  int checks;

  led_pattern_sequencer #(.W(16), .N_STEPS(8), .TICKS_PER_MS(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive a write now (away from edges), let one rising edge take it, release #1 later
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; wr_data = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    d = rd_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic expect_dout(input string tag, input int n, input logic [15:0] e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {16'd0, dout}, {16'd0, e});
    end
  endtask

  task automatic check_status(input string tag, input logic [31:0] e);
    logic [31:0] v;
    rd(5'd2, v);
    check(tag, v, e);
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] m;
    errors = 0; checks = 0;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1 reset state
    check("reset_dout", {16'd0, dout}, 32'd0);
    check_status("reset_status", 32'd0);
    for (int k = 16; k < 24; k++) begin
      rd(5'(k), v);
      check("reset_table", v, 32'd0);
    end

    // 2 one-shot
    wr(5'd16, {16'd2, 16'h00FF});
    wr(5'd17, {16'd3, 16'hFF00});
    wr(5'd1, 32'd2);
    rd(5'd17, v);
    check("table_rb", v, {16'd3, 16'hFF00});
    wr(5'd0, 32'h1);
    check_status("start_busy", 32'h1);
    expect_dout("os_step0", 20, 16'h00FF);
    expect_dout("os_step1", 30, 16'hFF00);
    expect_dout("os_end", 1, 16'h0000);
    check_status("os_done", 32'h2);

    // 3 loop then stop mid step 1
    wr(5'd0, 32'h5);
    expect_dout("lp_s0a", 20, 16'h00FF);
    expect_dout("lp_s1a", 30, 16'hFF00);
    expect_dout("lp_s0b", 20, 16'h00FF);
    expect_dout("lp_s1b", 10, 16'hFF00);
    wr(5'd0, 32'h2);
    expect_dout("stop_dout", 1, 16'h0000);
    check_status("stop_status", 32'h0);

    // 4 boundaries: zero duration, NSTEP=0, NSTEP=15, out-of-range step address
    wr(5'd16, {16'd0, 16'h0001});
    wr(5'd1, 32'd1);
    wr(5'd0, 32'h1);
    expect_dout("dur0", 10, 16'h0001);
    expect_dout("dur0_end", 1, 16'h0000);
    check_status("dur0_done", 32'h2);
    wr(5'd1, 32'd0);
    wr(5'd0, 32'h1);
    expect_dout("nstep0", 10, 16'h0001);
    expect_dout("nstep0_end", 1, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      m = 16'h0001 << k;
      wr(5'(16 + k), {16'd1, m});
    end
    wr(5'd1, 32'd15);
    rd(5'd1, v);
    check("nstep_rb", v, 32'd15);
    wr(5'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      m = 16'h0001 << k;
      expect_dout("nstep15", 10, m);
    end
    expect_dout("nstep15_end", 1, 16'h0000);
    check_status("nstep15_done", 32'h2);
    wr(5'd24, 32'hDEADBEEF);
    rd(5'd24, v);
    check("addr24", v, 32'd0);
    rd(5'd3, v);
    check("addr3", v, 32'd0);

    // 5 collisions
    wr(5'd0, 32'h3);
    expect_dout("ss_idle", 1, 16'h0000);
    check_status("ss_status", 32'h2);
    wr(5'd0, 32'h8);
    check_status("clr_done", 32'h0);
    wr(5'd16, {16'd2, 16'h00FF});
    wr(5'd17, {16'd3, 16'hFF00});
    wr(5'd1, 32'd2);
    wr(5'd0, 32'h1);
    expect_dout("rs_s0", 20, 16'h00FF);
    expect_dout("rs_s1", 5, 16'hFF00);
    wr(5'd0, 32'h1);
    expect_dout("rs_new_s0", 20, 16'h00FF);
    expect_dout("rs_new_s1", 30, 16'hFF00);
    expect_dout("rs_end", 1, 16'h0000);
    wr(5'd0, 32'h1);
    expect_dout("cd_s0", 20, 16'h00FF);
    expect_dout("cd_s1", 30, 16'hFF00);
    wr(5'd0, 32'h8);
    expect_dout("cd_end", 1, 16'h0000);
    check_status("cd_done_wins", 32'h2);

    // 6 live edit and reset mid-step
    wr(5'd0, 32'h1);
    expect_dout("le_s0a", 5, 16'h00FF);
    wr(5'd17, {16'd3, 16'hAAAA});
    expect_dout("le_s0b", 15, 16'h00FF);
    expect_dout("le_s1", 10, 16'hAAAA);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_dout("rst_dout", 1, 16'h0000);
    check_status("rst_status", 32'h0);
    rd(5'd17, v);
    check("rst_table", v, 32'd0);
    rd(5'd1, v);
    check("rst_nstep", v, 32'd0);
    expect_dout("rst_hold", 12, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
